dmem_resp_unit: RTL and testbench
=================================

Name: dmem_resp_unit

Overview:
- Data-memory responder on the store/load port of the OOO-OTTER. It receives the request from the store unit (and the load unit): address, write strobe, write data, size, sign.
- It stores or fetches data in a local word array after a fixed latency.
- It returns a one-cycle mem_resp_valid with mem_resp (1 = success, 0 = error). The store unit uses this response to signal completion to its reservation station.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array; power of two.
- LATENCY, 2, cycles from request accept to response; legal range 1..15.
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous active-high reset.
- MEM_ADDR2  in  32  byte address of the request.
- MEM_WRITE  in  1  store request; level, held by the requester until the response.
- MEM_READ2  in  1  load request; level, held by the requester until the response.
- MEM_WRITE_DATA  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- MEM_SIGN  in  1  1 = zero-extend loads, 0 = sign-extend (funct3[2]).
- MEM_SIZE  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- MEM_DOUT2  out  32  load data, extended; valid only while mem_resp_valid=1.
- mem_resp  out  1  1 = completed OK, 0 = error; meaningful only when mem_resp_valid=1.
- mem_resp_valid  out  1  one-cycle response strobe.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: state goes to IDLE and the latency counter clears. mem_resp_valid=0, mem_resp=0, MEM_DOUT2=0, busy=0. The array is not cleared; it is zero at time 0.
- Reset arriving in BUSY aborts the request. No array write happens and no response is issued.
- FSM states: IDLE, BUSY, RESP, DRAIN.
- IDLE: accept when MEM_WRITE | MEM_READ2 is high. The accept-cycle registers capture address, data, size, sign and op. The counter loads LATENCY-1. Next state is BUSY, or RESP directly when LATENCY=1.
- BUSY: counter decrements each cycle. Inputs are ignored and captured values are used. When the counter reaches 0, next state is RESP.
- RESP (one cycle):
  - mem_resp_valid=1.
  - A store with no error commits its byte-enabled write to the array at this clock edge.
  - A load drives MEM_DOUT2 from the array as read in this cycle.
  - Next state is DRAIN.
- DRAIN: wait until MEM_WRITE=0 and MEM_READ2=0, then go to IDLE. This stops a held level request from being accepted twice. The earliest re-accept is the first IDLE cycle.
- Response timing: a request accepted at edge T gives mem_resp_valid high during cycle T+LATENCY.
- Error (mem_resp=0, no write, MEM_DOUT2=0) is returned when any of these holds:
  - MEM_SIZE=3;
  - MEM_WRITE and MEM_READ2 are both high;
  - word index ((addr-BASE_ADDR)>>2) ≥ DEPTH_WORDS;
  - address is below BASE_ADDR;
  - misalignment (see Optional Feature).
- Byte lanes:
  - byte: lane addr[1:0];
  - half: lanes {addr[1],0}+{1,0};
  - word: all four lanes.
- Load extension:
  - The selected byte or half is shifted down to bit 0.
  - It is sign-extended from bit 7 or 15 when MEM_SIGN=0, and zero-extended otherwise.
- Load after store to the same word: the store commits in its RESP edge, so any later load reads the new data.

Optional Feature:
- Macro DMEM_MISALIGN_CHECK_EN.
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]≠0, returns an error with no write.
- Undefined: the low address bits are forced to alignment (half clears addr[0], word clears addr[1:0]). The access completes with mem_resp=1.

Decomposition:
- Shared package otter_mem_pkg holds:
  - enum mem_size_t {MEM_BYTE=0, MEM_HALF=1, MEM_WORD=2};
  - enum dmem_state_t {IDLE, BUSY, RESP, DRAIN};
  - constants MEM_RESP_OK=1, MEM_RESP_ERR=0.
- One sub-module, dmem_lane_align: a combinational function of size, addr[1:0] and sign. It produces the 4-bit byte-enable, the shifted write data, and the extracted/extended load data. It is shared with a future load unit.

Test Plan:
- Reset then word store: addr 0x10, data 0xDEADBEEF, SIZE=2, held, LATENCY=2 -> mem_resp_valid one cycle at accept+2, mem_resp=1, busy high from accept+1 until the request drops. Word load of 0x10 then returns 0xDEADBEEF.
- Byte store 0xA5 to 0x13, then byte load 0x13 -> MEM_SIGN=0 gives 0xFFFFFFA5; MEM_SIGN=1 gives 0x000000A5. Word 0x10 reads 0xA5ADBEEF.
- Request held high for 10 cycles after the response -> exactly one response. A second request accepted only after a low cycle gives a second response.
- Errors -> mem_resp=0, array unchanged, for each of:
  - SIZE=3;
  - MEM_WRITE and MEM_READ2 both high;
  - addr=BASE_ADDR+4*DEPTH_WORDS.
  - With DMEM_MISALIGN_CHECK_EN: word store to 0x22 errors. Without it, the same store writes word 0x20.
- RST asserted in BUSY for a word store of 0x12345678 to 0x40 -> no response, word 0x40 unchanged, all outputs 0 next cycle.
- LATENCY=1 -> response in the cycle after accept; back-to-back requests separated by one low cycle each complete correctly.

Source files
------------

// File: rtl/otter_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : otter_mem_pkg
// Brief    : Shared memory-port types and constants for the OOO-OTTER LSU path.
// Revision : 1.0 - initial release
// ============================================================================
package otter_mem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } dmem_state_t;

    localparam logic MEM_RESP_OK  = 1'b1;
    localparam logic MEM_RESP_ERR = 1'b0;

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lane_align
// Brief    : Byte-lane steering: byte enables, replicated store data and
//            extracted/extended load data for byte/half/word accesses.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_lane_align
    import otter_mem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_sign,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [1:0]  w_off;
    logic [15:0] w_low;

    // Sub-word offsets are forced to natural alignment; callers flag misalignment.
    always_comb begin
        w_off   = 2'd0;
        o_be    = 4'b0000;
        o_wdata = 32'd0;
        case (i_size)
            MEM_BYTE: begin
                w_off   = i_addr_lo;
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            MEM_HALF: begin
                w_off   = {i_addr_lo[1], 1'b0};
                o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
            end
            MEM_WORD: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
            end
            default: begin
                o_be    = 4'b0000;
            end
        endcase
    end

    assign w_low = 16'(i_rword >> {w_off, 3'b000});

    // i_sign = 1 selects zero extension (funct3[2]).
    always_comb begin
        o_rdata = 32'd0;
        case (i_size)
            MEM_BYTE: o_rdata = {{24{~i_sign & w_low[7]}}, w_low[7:0]};
            MEM_HALF: o_rdata = {{16{~i_sign & w_low[15]}}, w_low};
            MEM_WORD: o_rdata = i_rword;
            default:  o_rdata = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_resp_unit.sv
`default_nettype none
// ============================================================================
// Module   : dmem_resp_unit
// Brief    : Fixed-latency data-memory responder with one-cycle response strobe.
//            Optional macro DMEM_MISALIGN_CHECK_EN turns misaligned half/word
//            accesses into errors instead of forcing alignment.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_resp_unit
    import otter_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] MEM_ADDR2,
    input  logic        MEM_WRITE,
    input  logic        MEM_READ2,
    input  logic [31:0] MEM_WRITE_DATA,
    input  logic        MEM_SIGN,
    input  logic [1:0]  MEM_SIZE,
    output logic [31:0] MEM_DOUT2,
    output logic        mem_resp,
    output logic        mem_resp_valid,
    output logic        busy
);

    localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  C_CNT_INIT = 4'(LATENCY - 1);

    dmem_state_t r_state;
    dmem_state_t w_next;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_size;
    logic        r_sign;
    logic        r_we;
    logic        r_re;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic             w_req;
    logic             w_err;
    logic             w_commit;
    logic             w_below;
    logic             w_oob;
    logic             w_misalign;
    logic [29:0]      w_widx;
    logic [IDX_W-1:0] w_idx;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata_sh;
    logic [31:0]      w_rdata;
    logic [31:0]      w_rword;

    assign w_req = MEM_WRITE | MEM_READ2;

    // ---------------- state register ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_req) w_next = (LATENCY == 1) ? RESP : BUSY;
            BUSY:    if (r_cnt <= 4'd1) w_next = RESP;
            RESP:    w_next = DRAIN;
            DRAIN:   if (!w_req) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Request is captured once at accept; inputs are ignored until IDLE again.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt   <= 4'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_size  <= 2'd0;
            r_sign  <= 1'b0;
            r_we    <= 1'b0;
            r_re    <= 1'b0;
        end else if (r_state == IDLE && w_req) begin
            r_cnt   <= C_CNT_INIT;
            r_addr  <= MEM_ADDR2;
            r_wdata <= MEM_WRITE_DATA;
            r_size  <= MEM_SIZE;
            r_sign  <= MEM_SIGN;
            r_we    <= MEM_WRITE;
            r_re    <= MEM_READ2;
        end else if (r_state == BUSY && r_cnt != 4'd0) begin
            r_cnt   <= r_cnt - 4'd1;
        end
    end

    // ---------------- address decode and error checks ----------------
    assign w_widx  = r_addr[31:2] - BASE_ADDR[31:2];
    assign w_below = (r_addr < BASE_ADDR);
    assign w_oob   = (w_widx >= 30'(DEPTH_WORDS));
    assign w_idx   = w_widx[IDX_W-1:0];

`ifdef DMEM_MISALIGN_CHECK_EN
    assign w_misalign = ((r_size == MEM_HALF) && r_addr[0]) ||
                        ((r_size == MEM_WORD) && (r_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_err = (r_size == 2'd3) || (r_we && r_re) || w_below || w_oob || w_misalign;

    dmem_lane_align u_lane (
        .i_size    (r_size),
        .i_addr_lo (r_addr[1:0]),
        .i_sign    (r_sign),
        .i_wdata   (r_wdata),
        .i_rword   (w_rword),
        .o_be      (w_be),
        .o_wdata   (w_wdata_sh),
        .o_rdata   (w_rdata)
    );

    // ---------------- storage array ----------------
    assign w_rword  = r_mem[w_idx];
    assign w_commit = (r_state == RESP) && r_we && !r_re && !w_err && !RST;

    always_ff @(posedge CLK) begin
        if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        mem_resp_valid = 1'b0;
        mem_resp       = MEM_RESP_ERR;
        MEM_DOUT2      = 32'd0;
        busy           = (r_state != IDLE);
        if (r_state == RESP) begin
            mem_resp_valid = 1'b1;
            if (!w_err) begin
                mem_resp = MEM_RESP_OK;
                if (r_re) begin
                    MEM_DOUT2 = w_rdata;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_resp_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_resp_unit
// Brief    : Self-checking bench; two responders (LATENCY 2 and 1) against an
//            associative-array memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_resp_unit;

    logic        clk;
    logic        rst  [2];
    logic [31:0] addr [2];
    logic        we   [2];
    logic        re   [2];
    logic [31:0] wd   [2];
    logic        sgn  [2];
    logic [1:0]  sz   [2];
    logic [31:0] dout [2];
    logic        rsp  [2];
    logic        rv   [2];
    logic        bsy  [2];

    int          n_checks = 0;
    int          n_errors = 0;

    int unsigned lat_k   [2] = '{2, 1};
    int unsigned depth_k [2] = '{1024, 256};
    logic [31:0] base_k  [2] = '{32'h0000_0000, 32'h0000_1000};

    logic [31:0] mdl0 [int];
    logic [31:0] mdl1 [int];

    dmem_resp_unit #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(32'h0000_0000)) u_dut0 (
        .CLK(clk), .RST(rst[0]), .MEM_ADDR2(addr[0]), .MEM_WRITE(we[0]), .MEM_READ2(re[0]),
        .MEM_WRITE_DATA(wd[0]), .MEM_SIGN(sgn[0]), .MEM_SIZE(sz[0]), .MEM_DOUT2(dout[0]),
        .mem_resp(rsp[0]), .mem_resp_valid(rv[0]), .busy(bsy[0])
    );

    dmem_resp_unit #(.DEPTH_WORDS(256), .LATENCY(1), .BASE_ADDR(32'h0000_1000)) u_dut1 (
        .CLK(clk), .RST(rst[1]), .MEM_ADDR2(addr[1]), .MEM_WRITE(we[1]), .MEM_READ2(re[1]),
        .MEM_WRITE_DATA(wd[1]), .MEM_SIGN(sgn[1]), .MEM_SIZE(sz[1]), .MEM_DOUT2(dout[1]),
        .mem_resp(rsp[1]), .mem_resp_valid(rv[1]), .busy(bsy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mget(input int k, input int idx);
        if (k == 0) return mdl0.exists(idx) ? mdl0[idx] : 32'd0;
        return mdl1.exists(idx) ? mdl1[idx] : 32'd0;
    endfunction

    function automatic void mput(input int k, input int idx, input logic [31:0] v);
        if (k == 0) mdl0[idx] = v;
        else        mdl1[idx] = v;
    endfunction

    // Called at #1 after a clock edge with the selected DUT idle.
    task automatic do_req(input int k, input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] s, input logic sg, input int hold);
        logic        err;
        logic [31:0] off, wrd, ev, mask;
        int          idx, sh, cyc;
        off = a - base_k[k];
        idx = int'(off >> 2);
        err = (s == 2'd3) || (w && r) || (a < base_k[k]) || ((off >> 2) >= depth_k[k]);
`ifdef DMEM_MISALIGN_CHECK_EN
        err = err || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'b00);
`endif
        sh  = (s == 2'd0) ? 8 * int'(a[1:0]) : (s == 2'd1) ? (a[1] ? 16 : 0) : 0;
        wrd = err ? 32'd0 : mget(k, idx);
        ev  = 32'd0;
        if (!err && r) begin
            if (s == 2'd0) begin
                ev = (wrd >> sh) & 32'hFF;
                if (!sg && ev[7]) ev = ev | 32'hFFFF_FF00;
            end else if (s == 2'd1) begin
                ev = (wrd >> sh) & 32'hFFFF;
                if (!sg && ev[15]) ev = ev | 32'hFFFF_0000;
            end else begin
                ev = wrd;
            end
        end

        addr[k] = a; we[k] = w; re[k] = r; wd[k] = d; sz[k] = s; sgn[k] = sg;
        cyc = 0;
        while (cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (rv[k]) break;
            chk($sformatf("busy_wait[%0d]", k), 32'(bsy[k]), 32'd1);
        end
        if (!rv[k]) begin
            chk($sformatf("timeout[%0d]", k), 32'(rv[k]), 32'd1);
        end else begin
            chk($sformatf("latency[%0d]", k), 32'(cyc), 32'(lat_k[k]));
            chk($sformatf("resp[%0d] a=%h", k, a), 32'(rsp[k]), 32'(!err));
            if (err || r) chk($sformatf("dout[%0d] a=%h s=%0d", k, a, s), dout[k], ev);
        end

        if (!err && w) begin
            mask = (s == 2'd0) ? (32'hFF << sh) : (s == 2'd1) ? (32'hFFFF << sh) : 32'hFFFF_FFFF;
            mput(k, idx, (wrd & ~mask) | ((d << sh) & mask));
        end

        for (int i = 0; i <= hold; i++) begin
            @(posedge clk); #1;
            chk($sformatf("single_resp[%0d]", k), 32'(rv[k]), 32'd0);
        end
        we[k] = 1'b0; re[k] = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("idle_after[%0d]", k), 32'(bsy[k]), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic        w, r;
        logic [1:0]  s;
        int          sel;

        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; addr[k] = 32'd0; we[k] = 1'b0; re[k] = 1'b0;
            wd[k] = 32'd0; sgn[k] = 1'b0; sz[k] = 2'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_valid[%0d]", k), 32'(rv[k]), 32'd0);
            chk($sformatf("rst_resp[%0d]", k), 32'(rsp[k]), 32'd0);
            chk($sformatf("rst_dout[%0d]", k), dout[k], 32'd0);
            chk($sformatf("rst_busy[%0d]", k), 32'(bsy[k]), 32'd0);
            rst[k] = 1'b0;
        end

        // Seed the first 32 words of each array so every later load is defined.
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 32; i++)
                do_req(k, 1'b1, 1'b0, base_k[k] + 32'(4 * i), $urandom, 2'd2, 1'b0, 0);

        // Directed sequence on the LATENCY=2 responder.
        do_req(0, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 2'd2, 1'b0, 0);
        do_req(0, 1'b0, 1'b1, 32'h10, 32'h0, 2'd2, 1'b0, 0);
        do_req(0, 1'b1, 1'b0, 32'h13, 32'h0000_00A5, 2'd0, 1'b0, 0);
        do_req(0, 1'b0, 1'b1, 32'h13, 32'h0, 2'd0, 1'b0, 0);
        do_req(0, 1'b0, 1'b1, 32'h13, 32'h0, 2'd0, 1'b1, 0);
        do_req(0, 1'b0, 1'b1, 32'h10, 32'h0, 2'd2, 1'b0, 10);
        do_req(0, 1'b0, 1'b1, 32'h12, 32'h0, 2'd1, 1'b0, 0);
        do_req(0, 1'b1, 1'b0, 32'h10, 32'h1111_1111, 2'd3, 1'b0, 0);
        do_req(0, 1'b1, 1'b1, 32'h10, 32'h2222_2222, 2'd2, 1'b0, 0);
        do_req(0, 1'b1, 1'b0, 32'h1000, 32'h3333_3333, 2'd2, 1'b0, 0);
        do_req(0, 1'b0, 1'b1, 32'h10, 32'h0, 2'd2, 1'b0, 0);
        do_req(0, 1'b1, 1'b0, 32'hFFC, 32'h5A5A_0FF0, 2'd2, 1'b0, 0);
        do_req(0, 1'b0, 1'b1, 32'hFFC, 32'h0, 2'd2, 1'b0, 0);
        do_req(0, 1'b1, 1'b0, 32'h22, 32'h1122_3344, 2'd2, 1'b0, 0);
        do_req(0, 1'b0, 1'b1, 32'h20, 32'h0, 2'd2, 1'b0, 0);

        // Reset while the store is in flight.
        do_req(0, 1'b1, 1'b0, 32'h40, 32'hCAFE_F00D, 2'd2, 1'b0, 0);
        addr[0] = 32'h40; wd[0] = 32'h1234_5678; sz[0] = 2'd2; we[0] = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", 32'(bsy[0]), 32'd1);
        chk("abort_novalid_pre", 32'(rv[0]), 32'd0);
        rst[0] = 1'b1;
        @(posedge clk); #1;
        chk("abort_valid", 32'(rv[0]), 32'd0);
        chk("abort_resp", 32'(rsp[0]), 32'd0);
        chk("abort_dout", dout[0], 32'd0);
        chk("abort_busy_clr", 32'(bsy[0]), 32'd0);
        we[0] = 1'b0; rst[0] = 1'b0;
        @(posedge clk); #1;
        do_req(0, 1'b0, 1'b1, 32'h40, 32'h0, 2'd2, 1'b0, 0);

        // Boundary cases on the LATENCY=1 responder with a non-zero base.
        do_req(1, 1'b1, 1'b0, 32'h1000 + 32'(4 * 255), 32'h8765_4321, 2'd2, 1'b0, 0);
        do_req(1, 1'b0, 1'b1, 32'h1000 + 32'(4 * 255), 32'h0, 2'd1, 1'b0, 0);
        do_req(1, 1'b1, 1'b0, 32'h1000 + 32'(4 * 256), 32'h9999_9999, 2'd2, 1'b0, 0);
        do_req(1, 1'b1, 1'b0, 32'h0FFC, 32'h9999_9999, 2'd2, 1'b0, 0);
        do_req(1, 1'b0, 1'b1, 32'h1002, 32'h0, 2'd1, 1'b0, 0);

        // Randomized traffic on both responders.
        for (int k = 0; k < 2; k++) begin
            for (int it = 0; it < 60; it++) begin
                sel = int'($urandom_range(0, 11));
                a   = base_k[k] + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
                s   = 2'($urandom_range(0, 2));
                w   = (sel < 5);
                r   = !w;
                if (sel == 9)  s = 2'd3;
                if (sel == 10) begin w = 1'b1; r = 1'b1; end
                if (sel == 11) begin
                    if (k == 1 && $urandom_range(0, 1) == 1) a = base_k[k] - 32'($urandom_range(1, 16));
                    else a = base_k[k] + 32'(4 * depth_k[k]) + 32'($urandom_range(0, 15));
                end
                do_req(k, w, r, a, $urandom, s, 1'($urandom), int'($urandom_range(0, 3)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
